// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_mem_pkg
//  Description : Shared encodings for the unified instruction/data memory
//                port: access sizes, rw encoding, memory base address,
//                requester ids, arbiter states and a size-to-beats helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    // memory access_size encodings (burst length in words)
    localparam logic [1:0] SZ_1W  = 2'b00;
    localparam logic [1:0] SZ_4W  = 2'b01;
    localparam logic [1:0] SZ_8W  = 2'b10;
    localparam logic [1:0] SZ_16W = 2'b11;

    // memory rw encoding
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // base of the shared instruction/data RAM
    localparam logic [31:0] START_ADDR = 32'h8002_0000;

    // beat counter width: must hold 16
    localparam int BEAT_W = 5;

    typedef enum logic [1:0] {
        REQ_LD = 2'd0,
        REQ_DM = 2'd1,
        REQ_IF = 2'd2
    } req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_READ  = 2'd2
    } arb_state_t;

    function automatic logic [BEAT_W-1:0] beats_for_size(input logic [1:0] size);
        logic [BEAT_W-1:0] beats;
        case (size)
            SZ_1W:   beats = 5'd1;
            SZ_4W:   beats = 5'd4;
            SZ_8W:   beats = 5'd8;
            default: beats = 5'd16;
        endcase
        return beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : mem_port_arbiter_if
//  Description : Requester handshakes plus the memory-side bus of the single
//                memory port arbiter.
//  Modports    : master - the arbiter (drives gnt/rvalid/rdata and mem_*)
//                slave  - requesters and memory (drive req/operands, busy,
//                         data_out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // program loader: word writes
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    // data/memory stage: word loads and stores
    logic              dm_req;
    logic              dm_rw;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    // instruction fetch: burst reads
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [1:0]        if_size;
    logic              if_gnt;
    logic              if_rvalid;
    // shared read data
    logic [DATA_W-1:0] rdata;
    // memory side
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [1:0]        mem_access_size;
    logic              mem_rw;
    logic              mem_enable;
    logic              mem_busy;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        input  ld_req, ld_addr, ld_wdata,
        input  dm_req, dm_rw, dm_addr, dm_wdata,
        input  if_req, if_addr, if_size,
        input  mem_busy, mem_data_out,
        output ld_gnt, dm_gnt, dm_rvalid, if_gnt, if_rvalid, rdata,
        output mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable
    );

    modport slave (
        output ld_req, ld_addr, ld_wdata,
        output dm_req, dm_rw, dm_addr, dm_wdata,
        output if_req, if_addr, if_size,
        output mem_busy, mem_data_out,
        input  ld_gnt, dm_gnt, dm_rvalid, if_gnt, if_rvalid, rdata,
        input  mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable
    );

endinterface
`default_nettype wire

// File: rtl/mem_prio_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_prio_pick
//  Description : Combinational requester select. Loader always wins; the
//                data port beats fetch unless fetch is starved, in which case
//                fetch beats the data port.
//  Ports       : i_ld_req, i_dm_req, i_if_req - qualified requests
//                i_starved - starvation counter at its limit
//                o_valid   - at least one request present
//                o_winner  - id of the selected requester
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_prio_pick
    import mips_mem_pkg::*;
(
    input  wire logic i_ld_req,
    input  wire logic i_dm_req,
    input  wire logic i_if_req,
    input  wire logic i_starved,
    output logic      o_valid,
    output req_id_t   o_winner
);

    always_comb begin
        o_valid  = i_ld_req | i_dm_req | i_if_req;
        o_winner = REQ_LD;
        if (i_ld_req) begin
            o_winner = REQ_LD;
        end else if (i_if_req && i_starved) begin
            o_winner = REQ_IF;
        end else if (i_dm_req) begin
            o_winner = REQ_DM;
        end else if (i_if_req) begin
            o_winner = REQ_IF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Single-port arbiter/sequencer in front of the unified memory.
//                Arbitrates loader writes, data-port loads/stores and fetch
//                bursts; one transaction outstanding at a time; honours the
//                memory busy handshake and returns read data with rvalid.
//  Ports       : clock   - system clock, rising edge
//                reset_n - asynchronous active-low reset
//                bus     - requester handshakes and memory bus (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    mem_port_arbiter_if.master bus
);

    localparam int                    c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    arb_state_t            r_state;
    req_id_t               r_owner;
    logic [BEAT_W-1:0]     r_beats;
    logic [c_STARVE_W-1:0] r_starve_cnt;

    logic                  r_ld_gnt;
    logic                  r_dm_gnt;
    logic                  r_if_gnt;
    logic                  r_dm_rvalid;
    logic                  r_if_rvalid;
    logic [DATA_W-1:0]     r_rdata;

    // The mem_* registers double as the latched copy of the winning request.
    logic [ADDR_W-1:0]     r_mem_address;
    logic [DATA_W-1:0]     r_mem_data_in;
    logic [1:0]            r_mem_access_size;
    logic                  r_mem_rw;
    logic                  r_mem_enable;

    logic                  w_ld_req;
    logic                  w_dm_req;
    logic                  w_if_req;
    logic                  w_starved;
    logic                  w_any_req;
    req_id_t               w_winner;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic                  w_sel_rw;
    logic [1:0]            w_sel_size;

    // A write's gnt pulse lands in the IDLE cycle where the requester may
    // still show req high; masking it there prevents re-issuing the same write.
    assign w_ld_req  = bus.ld_req & ~r_ld_gnt;
    assign w_dm_req  = bus.dm_req & ~r_dm_gnt;
    assign w_if_req  = bus.if_req & ~r_if_gnt;
    assign w_starved = (r_starve_cnt == c_STARVE_MAX);

    mem_prio_pick u_prio_pick (
        .i_ld_req  (w_ld_req),
        .i_dm_req  (w_dm_req),
        .i_if_req  (w_if_req),
        .i_starved (w_starved),
        .o_valid   (w_any_req),
        .o_winner  (w_winner)
    );

    // Operands of the winner; single-word accesses (all writes and data
    // loads) always use SZ_1W, only fetch carries its own burst size.
    always_comb begin
        w_sel_addr  = bus.ld_addr;
        w_sel_wdata = bus.ld_wdata;
        w_sel_rw    = RW_WRITE;
        w_sel_size  = SZ_1W;
        case (w_winner)
            REQ_DM: begin
                w_sel_addr  = bus.dm_addr;
                w_sel_wdata = bus.dm_wdata;
                w_sel_rw    = bus.dm_rw;
                w_sel_size  = SZ_1W;
            end
            REQ_IF: begin
                w_sel_addr  = bus.if_addr;
                w_sel_wdata = '0;
                w_sel_rw    = RW_READ;
                w_sel_size  = bus.if_size;
            end
            default: begin
                w_sel_addr  = bus.ld_addr;
                w_sel_wdata = bus.ld_wdata;
                w_sel_rw    = RW_WRITE;
                w_sel_size  = SZ_1W;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= ST_IDLE;
            r_owner           <= REQ_LD;
            r_beats           <= '0;
            r_starve_cnt      <= '0;
            r_ld_gnt          <= 1'b0;
            r_dm_gnt          <= 1'b0;
            r_if_gnt          <= 1'b0;
            r_dm_rvalid       <= 1'b0;
            r_if_rvalid       <= 1'b0;
            r_rdata           <= '0;
            r_mem_address     <= '0;
            r_mem_data_in     <= '0;
            r_mem_access_size <= '0;
            r_mem_rw          <= 1'b0;
            r_mem_enable      <= 1'b0;
        end else begin
            // gnt and rvalid are single-cycle pulses
            r_ld_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rvalid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner           <= w_winner;
                        r_mem_address     <= w_sel_addr;
                        r_mem_data_in     <= w_sel_wdata;
                        r_mem_rw          <= w_sel_rw;
                        r_mem_access_size <= w_sel_size;
                        r_mem_enable      <= 1'b1;
                        r_state           <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // while busy everything simply holds
                    if (!bus.mem_busy) begin
                        r_mem_enable <= 1'b0;
                        case (r_owner)
                            REQ_DM:  r_dm_gnt <= 1'b1;
                            REQ_IF:  r_if_gnt <= 1'b1;
                            default: r_ld_gnt <= 1'b1;
                        endcase

                        if (r_owner == REQ_IF || !bus.if_req) begin
                            r_starve_cnt <= '0;
                        end else if (r_owner == REQ_DM && r_starve_cnt != c_STARVE_MAX) begin
                            r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
                        end

                        if (r_mem_rw == RW_READ) begin
                            r_beats <= beats_for_size(r_mem_access_size);
                            r_state <= ST_READ;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_READ: begin
                    r_rdata <= bus.mem_data_out;
                    if (r_owner == REQ_IF) begin
                        r_if_rvalid <= 1'b1;
                    end else begin
                        r_dm_rvalid <= 1'b1;
                    end
                    r_beats <= r_beats - BEAT_W'(1);
                    if (r_beats == BEAT_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ld_gnt          = r_ld_gnt;
    assign bus.dm_gnt          = r_dm_gnt;
    assign bus.if_gnt          = r_if_gnt;
    assign bus.dm_rvalid       = r_dm_rvalid;
    assign bus.if_rvalid       = r_if_rvalid;
    assign bus.rdata           = r_rdata;
    assign bus.mem_address     = r_mem_address;
    assign bus.mem_data_in     = r_mem_data_in;
    assign bus.mem_access_size = r_mem_access_size;
    assign bus.mem_rw          = r_mem_rw;
    assign bus.mem_enable      = r_mem_enable;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-port arbiter and sequencer in front of the unified `memory` block (shared instruction/data RAM at 0x80020000).
- Three requesters share the port:
  - program loader: word writes;
  - data/memory stage: word loads and stores;
  - instruction fetch: burst reads.
- Issues one transaction at a time and honours the memory `busy` handshake.
- Returns read data to the owning requester with a valid pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data-port grants allowed while fetch waits before fetch wins.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- ld_req  in  1  loader write request
- ld_addr  in  32  loader word address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  loader request accepted by memory (1-cycle pulse)
- dm_req  in  1  data-port request
- dm_rw  in  1  0=store, 1=load (memory rw encoding)
- dm_addr  in  32  data-port address
- dm_wdata  in  32  store data
- dm_gnt  out  1  data-port accepted (pulse)
- dm_rvalid  out  1  load data valid on rdata (pulse)
- if_req  in  1  fetch read request
- if_addr  in  32  fetch start address
- if_size  in  2  burst size: 00=1, 01=4, 10=8, 11=16 words
- if_gnt  out  1  fetch accepted (pulse)
- if_rvalid  out  1  fetch beat valid on rdata
- rdata  out  32  registered read data, shared by requesters
- mem_address  out  32  to memory address
- mem_data_in  out  32  to memory data_in
- mem_access_size  out  2  to memory access_size
- mem_rw  out  1  to memory rw (0=write, 1=read)
- mem_enable  out  1  to memory enable
- mem_busy  in  1  from memory busy
- mem_data_out  in  32  from memory data_out

Behaviour:

Reset:
- Asynchronous on reset_n=0.
- State goes to IDLE; starvation counter and beat counter go to 0.
- Every output goes to 0, including rdata and mem_* signals.
- Reset during a burst aborts it: no further rvalid and no gnt.

FSM states:
- IDLE:
  - On an edge with any req high, arbitrate, latch the winner's id, addr, wdata, rw and size, and go to ISSUE.
  - Priority is ld > dm > if.
  - If the starvation counter equals STARVE_LIMIT and if_req=1, fetch beats dm. The loader still wins.
- ISSUE:
  - mem_enable=1 and mem_* driven from the latches.
  - Writes force mem_access_size=00.
  - dm loads use 00; fetch uses the latched if_size.
  - Edge with mem_busy=1: stay in ISSUE, hold all mem_* outputs.
  - Edge with mem_busy=0: accepted. Pulse the winner's gnt next cycle.
    - Write: go to IDLE.
    - Read: load the beat counter with 1, 4, 8 or 16, then go to READ.
- READ:
  - mem_enable=0.
  - Memory presents one word per cycle, starting the cycle after acceptance.
  - Each edge: rdata<=mem_data_out, pulse the owner's rvalid, decrement the counter.
  - When the last beat is captured, go to IDLE.
  - mem_busy is ignored in READ.

Latency and ordering:
- Read latency: req sampled at edge N, acceptance at N+1 (if not busy), first rvalid high after edge N+2.
- A 4-word burst gives rvalid on 4 consecutive cycles.
- Exactly one transaction is outstanding. New arbitration happens only from IDLE, so there is at least one IDLE cycle between transactions.

Requester rules:
- Each requester holds req and its operands until its gnt.
- The latched copy is authoritative; a req dropped after latching does not cancel the transaction.

Starvation counter:
- Increments on each dm acceptance while if_req=1, saturating at STARVE_LIMIT.
- Clears on any if acceptance, or when if_req=0 at an acceptance.

Boundaries:
- Simultaneous reqs resolve per the priority rules above.
- No address wrap handling: the memory increments burst addresses internally.

Decomposition:
- Shared package mips_mem_pkg:
  - access_size encodings (SZ_1W, SZ_4W, SZ_8W, SZ_16W);
  - RW_WRITE=0 and RW_READ=1;
  - START_ADDR=32'h80020000;
  - requester id enum (REQ_LD, REQ_DM, REQ_IF).
- One sub-module, mem_prio_pick: combinational priority/starvation select, returning the winner id.

Test Plan:
- Reset:
  - Stimulus: hold reset_n=0 mid-READ of a 16-word fetch.
  - Response: all outputs 0 immediately; after release, IDLE with no stray rvalid.
- Loader writes:
  - Stimulus: ld_req with addr 0x80020000, 0x80020004 and data 0x27BDFFF8, 0xAFBE0004.
  - Response: mem_rw=0, mem_access_size=00, mem_enable for one cycle each; ld_gnt pulses.
- Fetch burst:
  - Stimulus: if_req, if_addr=0x80020000, if_size=01.
  - Response: if_gnt one cycle after acceptance; four consecutive if_rvalid pulses with the memory words in order; first rvalid 2 cycles after acceptance edge.
- Busy hold:
  - Stimulus: mem_busy=1 for 3 cycles during ISSUE of a dm load.
  - Response: mem_* outputs stable for 4 cycles; dm_gnt only after busy drops; one dm_rvalid.
- Priority and starvation:
  - Stimulus: ld_req, dm_req and if_req all high together.
  - Response: loader first.
  - Stimulus: then continuous dm_req and if_req with STARVE_LIMIT=4.
  - Response: grant order dm, dm, dm, dm, if, dm.
